sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have port aclk, input, 1, single clock for the block; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_i, input, NUM_REQ, per-requester access request.
REQ-007 SHALL have port we_i, input, NUM_REQ, per-requester write (1) / read (0).
REQ-008 SHALL have port last_i, input, NUM_REQ, marks the final beat of a requester's burst.
REQ-009 SHALL have port be_i, input, NUM_REQ x STRB_WIDTH, byte enables.
REQ-010 SHALL have port addr_i, input, NUM_REQ x ADDR_WIDTH, byte address.
REQ-011 SHALL have port wdata_i, input, NUM_REQ x DATA_WIDTH, write data.
REQ-012 SHALL have port gnt_o, output, NUM_REQ, one-hot beat accept.
REQ-013 SHALL have port rvalid_o, output, NUM_REQ, read data valid, one-hot.
REQ-014 SHALL have port rdata_o, output, DATA_WIDTH, read data shared by all requesters.
REQ-015 SHALL have port ram_en_o / ram_wen_o, output, 1 each, active-high SRAM enable / write enable.
REQ-016 SHALL have port ram_bm_o, ram_addr_o, ram_dat_o, output, STRB_WIDTH / ADDR_WIDTH / DATA_WIDTH, to SRAM.
REQ-017 SHALL have port ram_dat_i, input, DATA_WIDTH, SRAM read data, valid one cycle after a read enable.

Function
REQ-018 SHALL implement states IDLE and LOCKED; reset state IDLE.
REQ-019 In IDLE with any req_i set, SHALL grant the first requesting index at or after rr_ptr (circular), same cycle, combinationally.
REQ-020 On a grant with last_i=0, SHALL enter LOCKED holding owner index; with last_i=1, SHALL stay IDLE.
REQ-021 In LOCKED, SHALL grant only the owner, whenever req_i[owner]=1; other requests stall.
REQ-022 In LOCKED, a granted beat with last_i[owner]=1 SHALL return to IDLE.
REQ-023 rr_ptr SHALL update to (granted index + 1) mod NUM_REQ only on the beat that ends a burst (last_i=1).
REQ-024 gnt_o SHALL be one-hot or zero; gnt_o[i] implies req_i[i].
REQ-025 On any grant, SHALL drive ram_en_o=1, ram_wen_o=we_i, ram_bm_o/ram_addr_o/ram_dat_o from the granted requester; otherwise ram_en_o=0, ram_wen_o=0, other ram outputs 0.
REQ-026 A granted read SHALL assert rvalid_o[index] exactly one cycle later with rdata_o=ram_dat_i; writes SHALL produce no rvalid.
REQ-027 Back-to-back reads SHALL sustain one beat per cycle with no bubbles.
REQ-028 Owner dropping req_i mid-burst in LOCKED SHALL keep lock; no other requester granted until owner's last beat.
REQ-029 Simultaneous requests in IDLE SHALL resolve solely by rr_ptr; no starvation: each waiting requester is granted within NUM_REQ bursts.
REQ-030 rdata_o SHALL equal ram_dat_i combinationally; meaningful only when rvalid_o nonzero.

Reset
REQ-031 Asserting areset SHALL immediately force state IDLE, rr_ptr 0, owner 0, pending-read flag 0.
REQ-032 During reset, gnt_o, rvalid_o, ram_en_o, ram_wen_o SHALL be 0; a read granted in the cycle before reset SHALL produce no rvalid.
REQ-033 Reset mid-burst SHALL discard the lock; after release arbitration restarts from index 0.

Structure
REQ-034 State enum (IDLE, LOCKED) SHALL live in a shared package sram_arb_pkg.
REQ-035 Round-robin priority selection SHALL be one sub-module rr_pick (req vector + pointer -> one-hot + index).
REQ-036 Registers SHALL be: state, owner, rr_ptr, rd_pend, rd_idx; no other storage.

Verification
REQ-037 req_i=2'b11, both reads, last=1, after reset -> gnt 01 then 10 on consecutive cycles; rvalid 01 then 10 one cycle after each.
REQ-038 Req0 4-beat write burst (last on beat 4), req1 asserted from cycle 1 -> req1 granted only in cycle after req0 beat 4.
REQ-039 Req0 read addr 0x10 with ram_dat_i=0xDEADBEEF next cycle -> rvalid_o=01, rdata_o=0xDEADBEEF.
REQ-040 Req0 drops req_i for 2 cycles mid-burst while req1 requests -> gnt_o=0 those cycles, req0 resumes.
REQ-041 areset pulsed during LOCKED burst of req1 with read outstanding -> no rvalid, next idle grant to req0 when both request.
REQ-042 NUM_REQ=4, all requesting single beats continuously -> grant order 0,1,2,3,0 repeating.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: the lock-state encoding used by the top level.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting index at or after ptr, wrapping circularly,
// as both a one-hot vector and a binary index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] below_ptr_s;
    logic [N-1:0] upper_req_s;
    logic [N-1:0] search_s;

    // Prefer requests at or above the pointer; fall back to the full vector to wrap around.
    assign below_ptr_s = (ONE << ptr) - ONE;
    assign upper_req_s = req & ~below_ptr_s;
    assign search_s    = (|upper_req_s) ? upper_req_s : req;
    assign gnt         = search_s & (~search_s + ONE);
    assign valid       = |req;

    // Binary encode of the one-hot pick.
    always_comb begin
        idx = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = gnt[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-requester single-port SRAM arbiter with round-robin selection and burst locking.
// Grants are combinational; read data returns one cycle after the read beat.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ-1:0]               last_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             ram_en_o,
    output logic                             ram_wen_o,
    output logic [STRB_WIDTH-1:0]            ram_bm_o,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic [DATA_WIDTH-1:0]            ram_dat_o,
    input  logic [DATA_WIDTH-1:0]            ram_dat_i
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e        state_r;
    logic [IW-1:0]     owner_r;
    logic [IW-1:0]     rr_ptr_r;
    logic              rd_pend_r;
    logic [IW-1:0]     rd_idx_r;

    logic [NUM_REQ-1:0] pick_gnt_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_valid_s;
    logic [IW-1:0]      sel_idx_s;
    logic               sel_valid_s;
    logic               grant_s;
    logic [IW-1:0]      next_ptr_s;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Select the beat to accept: round-robin pick when idle, only the owner while locked.
    always_comb begin
        sel_idx_s   = {IW{1'b0}};
        sel_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                sel_idx_s   = pick_idx_s;
                sel_valid_s = pick_valid_s & (|pick_gnt_s);
            end
            LOCKED: begin
                sel_idx_s   = owner_r;
                sel_valid_s = req_i[owner_r];
            end
            default: begin
                sel_idx_s   = {IW{1'b0}};
                sel_valid_s = 1'b0;
            end
        endcase
    end

    // Reset masks the grant so nothing reaches the SRAM while areset is high.
    assign grant_s    = sel_valid_s & ~areset;
    assign next_ptr_s = (sel_idx_s == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : sel_idx_s + IW'(1);

    assign gnt_o      = grant_s ? (ONE << sel_idx_s) : {NUM_REQ{1'b0}};
    assign ram_en_o   = grant_s;
    assign ram_wen_o  = grant_s & we_i[sel_idx_s];
    assign ram_bm_o   = grant_s ? be_i[sel_idx_s*STRB_WIDTH +: STRB_WIDTH] : {STRB_WIDTH{1'b0}};
    assign ram_addr_o = grant_s ? addr_i[sel_idx_s*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}};
    assign ram_dat_o  = grant_s ? wdata_i[sel_idx_s*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    assign rvalid_o   = (rd_pend_r & ~areset) ? (ONE << rd_idx_r) : {NUM_REQ{1'b0}};
    assign rdata_o    = ram_dat_i;

    // Lock FSM, round-robin pointer and one-deep read-return tracking.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r   <= IDLE;
            owner_r   <= {IW{1'b0}};
            rr_ptr_r  <= {IW{1'b0}};
            rd_pend_r <= 1'b0;
            rd_idx_r  <= {IW{1'b0}};
        end else begin
            rd_pend_r <= sel_valid_s & ~we_i[sel_idx_s];
            rd_idx_r  <= sel_idx_s;
            if (sel_valid_s) begin
                if (last_i[sel_idx_s]) begin
                    state_r  <= IDLE;
                    rr_ptr_r <= next_ptr_s;
                end else begin
                    state_r  <= LOCKED;
                    owner_r  <= sel_idx_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a per-cycle vector table for the 2-requester
// instance plus hand sequences for read data, reset mid-burst and 4-requester rotation.
module tb_sram_port_arbiter;

    logic        aclk;
    logic        areset;
    logic [1:0]  req_i, we_i, last_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i, wdata_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        ram_en_o, ram_wen_o;
    logic [3:0]  ram_bm_o;
    logic [31:0] ram_addr_o, ram_dat_o, ram_dat_i;

    logic [3:0]   req4, we4, last4;
    logic [15:0]  be4;
    logic [127:0] addr4, wdata4;
    logic [3:0]   gnt4, rvalid4;
    logic [31:0]  rdata4;
    logic         ram_en4, ram_wen4;
    logic [3:0]   ram_bm4;
    logic [31:0]  ram_addr4, ram_dat4_o, ram_dat4_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    sram_port_arbiter dut (
        .aclk(aclk), .areset(areset), .req_i(req_i), .we_i(we_i), .last_i(last_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o), .ram_bm_o(ram_bm_o),
        .ram_addr_o(ram_addr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    sram_port_arbiter #(.NUM_REQ(4)) dut4 (
        .aclk(aclk), .areset(areset), .req_i(req4), .we_i(we4), .last_i(last4),
        .be_i(be4), .addr_i(addr4), .wdata_i(wdata4), .gnt_o(gnt4), .rvalid_o(rvalid4),
        .rdata_o(rdata4), .ram_en_o(ram_en4), .ram_wen_o(ram_wen4), .ram_bm_o(ram_bm4),
        .ram_addr_o(ram_addr4), .ram_dat_o(ram_dat4_o), .ram_dat_i(ram_dat4_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [1:0] last;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rvalid;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e_addr, e_dat;
        logic [3:0]  e_bm;
        logic [1:0]  g;
        logic [3:0]  e_g4, e_rv4;

        // req, we, last, expected gnt, expected rvalid (from previous cycle's read)
        tbl[0]  = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b00};
        tbl[1]  = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[3]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        tbl[4]  = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b00};
        tbl[5]  = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b00};
        tbl[6]  = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
        tbl[7]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        tbl[8]  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[9]  = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
        tbl[10] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        tbl[11] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b00};
        tbl[12] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
        tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[14] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[15] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
        tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

        addr_i    = {32'h0000_0020, 32'h0000_0010};
        wdata_i   = {32'hB1B1_0001, 32'hA0A0_0000};
        be_i      = {4'hC, 4'h3};
        ram_dat_i = 32'h0;
        req4 = 4'h0; we4 = 4'h0; last4 = 4'h0;
        be4        = 16'h8421;
        addr4      = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        wdata4     = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
        ram_dat4_i = 32'h7777_0000;

        // Reset holds every output quiet even with requests present.
        areset = 1'b1;
        req_i = 2'b11; we_i = 2'b11; last_i = 2'b00;
        @(negedge aclk);
        #2;
        chk("reset gnt", 64'(gnt_o), 64'h0);
        chk("reset rvalid", 64'(rvalid_o), 64'h0);
        chk("reset ram_en", 64'(ram_en_o), 64'h0);
        chk("reset ram_wen", 64'(ram_wen_o), 64'h0);
        @(negedge aclk);
        areset = 1'b0;
        req_i = 2'b00; we_i = 2'b00; last_i = 2'b00;

        for (int i = 0; i < 17; i++) begin
            @(negedge aclk);
            req_i     = tbl[i].req;
            we_i      = tbl[i].we;
            last_i    = tbl[i].last;
            ram_dat_i = 32'hC000_0000 + 32'(i);
            #2;
            g      = tbl[i].exp_gnt;
            e_addr = g[0] ? 32'h10 : (g[1] ? 32'h20 : 32'h0);
            e_dat  = g[0] ? 32'hA0A0_0000 : (g[1] ? 32'hB1B1_0001 : 32'h0);
            e_bm   = g[0] ? 4'h3 : (g[1] ? 4'hC : 4'h0);
            chk($sformatf("row%0d gnt", i), 64'(gnt_o), 64'(g));
            chk($sformatf("row%0d rvalid", i), 64'(rvalid_o), 64'(tbl[i].exp_rvalid));
            chk($sformatf("row%0d ram_en", i), 64'(ram_en_o), 64'(|g));
            chk($sformatf("row%0d ram_wen", i), 64'(ram_wen_o), 64'(|(g & tbl[i].we)));
            chk($sformatf("row%0d ram_addr", i), 64'(ram_addr_o), 64'(e_addr));
            chk($sformatf("row%0d ram_dat", i), 64'(ram_dat_o), 64'(e_dat));
            chk($sformatf("row%0d ram_bm", i), 64'(ram_bm_o), 64'(e_bm));
            if (tbl[i].exp_rvalid != 2'b00) begin
                chk($sformatf("row%0d rdata", i), 64'(rdata_o), 64'(32'hC000_0000 + 32'(i)));
            end
        end

        // Single read from req0 returns SRAM data the following cycle.
        @(negedge aclk);
        req_i = 2'b01; we_i = 2'b00; last_i = 2'b01;
        #2;
        chk("rd gnt", 64'(gnt_o), 64'h1);
        chk("rd ram_addr", 64'(ram_addr_o), 64'h10);
        chk("rd ram_en", 64'(ram_en_o), 64'h1);
        @(negedge aclk);
        req_i = 2'b00; ram_dat_i = 32'hDEAD_BEEF;
        #2;
        chk("rd rvalid", 64'(rvalid_o), 64'h1);
        chk("rd rdata", 64'(rdata_o), 64'hDEAD_BEEF);

        // Reset during req1's locked read burst drops the lock and the pending read.
        @(negedge aclk);
        req_i = 2'b10; we_i = 2'b00; last_i = 2'b00;
        #2;
        chk("rst_burst gnt", 64'(gnt_o), 64'h2);
        @(negedge aclk);
        areset = 1'b1;
        req_i = 2'b11; last_i = 2'b11;
        #2;
        chk("rst_burst rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_burst gnt_in_rst", 64'(gnt_o), 64'h0);
        chk("rst_burst ram_en", 64'(ram_en_o), 64'h0);
        @(negedge aclk);
        #2;
        chk("rst_burst rvalid2", 64'(rvalid_o), 64'h0);
        @(negedge aclk);
        areset = 1'b0;
        #2;
        chk("post_rst gnt", 64'(gnt_o), 64'h1);
        @(negedge aclk);
        req_i = 2'b00;
        #2;
        chk("post_rst rvalid", 64'(rvalid_o), 64'h1);

        // Four requesters all issuing single-beat reads rotate 0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            req4 = 4'hF; we4 = 4'h0; last4 = 4'hF;
            #2;
            e_g4  = 4'b0001 << (k % 4);
            e_rv4 = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
            chk($sformatf("rr4 k%0d gnt", k), 64'(gnt4), 64'(e_g4));
            chk($sformatf("rr4 k%0d rvalid", k), 64'(rvalid4), 64'(e_rv4));
            chk($sformatf("rr4 k%0d ram_addr", k), 64'(ram_addr4), 64'(32'h100 * (k % 4)));
            chk($sformatf("rr4 k%0d ram_dat", k), 64'(ram_dat4_o), 64'(32'h5000_0000 + 32'(k % 4)));
            chk($sformatf("rr4 k%0d ram_bm", k), 64'(ram_bm4), 64'(e_g4));
            chk($sformatf("rr4 k%0d en_wen", k), 64'({ram_en4, ram_wen4}), 64'h2);
            chk($sformatf("rr4 k%0d rdata", k), 64'(rdata4), 64'h7777_0000);
        end
        @(negedge aclk);
        req4 = 4'h0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
